pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one generic payload word plus a control field between two pipeline stages.
- Replaces the hard-wired per-signal flops with a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and bubble insertion that zeroes the control field.
- Any stage boundary in the core can instantiate it, sizing the payload and control widths to suit.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_slot.sv | 51 +++++
 rtl/pipe_stage_buf.sv | 130 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: occupancy codes,
// default stage-boundary widths and payload field offsets for instantiators.
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   localparam int unsigned IFID_DATA_W  = 64;
   localparam int unsigned IFID_CTRL_W  = 4;
   localparam int unsigned IDEX_DATA_W  = 128;
   localparam int unsigned IDEX_CTRL_W  = 8;
   localparam int unsigned EXMEM_DATA_W = 128;
   localparam int unsigned EXMEM_CTRL_W = 8;
   localparam int unsigned MEMWB_DATA_W = 64;
   localparam int unsigned MEMWB_CTRL_W = 4;

   // EX/MEM payload layout: {rd, pc, store data, alu result}
   localparam int unsigned EXMEM_ALU_LSB   = 0;
   localparam int unsigned EXMEM_STORE_LSB = 32;
   localparam int unsigned EXMEM_PC_LSB    = 64;
   localparam int unsigned EXMEM_RD_LSB    = 96;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } pipe_state_e;

   function automatic logic [1:0] state_occ(input pipe_state_e st);
      logic [1:0] occ;
      case (st)
         StOne:   occ = OCC_ONE;
         StFull:  occ = OCC_FULL;
         default: occ = OCC_EMPTY;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload and control, loaded or cleared
// by the owning state machine. Payload is retained when the entry is cleared.
module pipe_slot #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         ctrl_d  = ctrl_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and bubble control gating.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [1:0]        occ_o
);

   pipe_state_e st_q, st_d;
   logic        in_ready_q, in_ready_d;
   logic        accept, consume;
   logic        head_load, head_clear, head_from_skid, skid_load, skid_clear;
   logic        head_valid, skid_valid;

   logic [DATA_W-1:0] head_data, skid_data, head_in_data;
   logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_in_ctrl;

   // Without a skid entry the stage can only take data when the head drains.
   assign in_ready_o = (SKID != 0) ? in_ready_q : (!head_valid || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign consume    = head_valid && out_ready_i;

   always_comb begin
      st_d           = st_q;
      head_load      = 1'b0;
      head_clear     = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush_i) begin
         st_d       = StEmpty;
         head_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (st_q)
            StEmpty: begin
               if (accept) begin
                  head_load = 1'b1;
                  st_d      = StOne;
               end
            end
            StOne: begin
               if (accept && consume) begin
                  head_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  st_d      = StFull;
               end else if (consume) begin
                  head_clear = 1'b1;
                  st_d       = StEmpty;
               end
            end
            StFull: begin
               if (consume) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  skid_clear     = 1'b1;
                  st_d           = StOne;
               end
            end
            default: st_d = StEmpty;
         endcase
      end
      in_ready_d = (st_d != StFull);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q       <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         st_q       <= st_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign head_in_data = head_from_skid ? skid_data : in_data_i;
   assign head_in_ctrl = head_from_skid ? skid_ctrl : in_ctrl_i;

   pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
   ) u_head (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (head_load),
      .clear_i(head_clear),
      .data_i (head_in_data),
      .ctrl_i (head_in_ctrl),
      .valid_o(head_valid),
      .data_o (head_data),
      .ctrl_o (head_ctrl)
   );

   pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
   ) u_skid (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (skid_load),
      .clear_i(skid_clear),
      .data_i (in_data_i),
      .ctrl_i (in_ctrl_i),
      .valid_o(skid_valid),
      .data_o (skid_data),
      .ctrl_o (skid_ctrl)
   );

   assign out_valid_o = head_valid;
   assign out_data_o  = head_data;
   assign out_ctrl_o  = head_valid ? head_ctrl : '0;
   assign occ_o       = state_occ(st_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances share stimulus and are
// checked every cycle against queue models, plus directed literal checks.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        out_ready = 1'b0;

   logic        in_ready1, out_valid1, in_ready0, out_valid0;
   logic [31:0] out_data1, out_data0;
   logic [7:0]  out_ctrl1, out_ctrl0;
   logic [1:0]  occ1, occ0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready1), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
      .out_ctrl_o(out_ctrl1), .occ_o(occ1)
   );

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready0), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
      .out_ctrl_o(out_ctrl0), .occ_o(occ0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Models: FIFO of {ctrl,data}, capacity 2 (skid) or 1 (no skid).
   logic [39:0] q1[$];
   logic [39:0] q0[$];
   logic        acc1, con1, acc0, con0;

   always @(negedge rst_n) begin
      q1.delete();
      q0.delete();
   end

   always @(posedge clk) begin
      if (rst_n) begin
         acc1 = in_valid && (q1.size() < 2);
         con1 = (q1.size() > 0) && out_ready;
         acc0 = in_valid && ((q0.size() == 0) || out_ready);
         con0 = (q0.size() > 0) && out_ready;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (con1) void'(q1.pop_front());
            if (acc1) q1.push_back({in_ctrl, in_data});
            if (con0) void'(q0.pop_front());
            if (acc0) q0.push_back({in_ctrl, in_data});
         end
      end
   end

   always @(negedge clk) begin
      chk("valid1", out_valid1, q1.size() != 0);
      chk("occ1", occ1, q1.size());
      chk("ready1", in_ready1, q1.size() < 2);
      chk("occ_full_vs_ready1", occ1 == 2'd2, !in_ready1);
      if (q1.size() != 0) begin
         chk("data1", out_data1, q1[0][31:0]);
         chk("ctrl1", out_ctrl1, q1[0][39:32]);
      end else begin
         chk("bubble_ctrl1", out_ctrl1, 8'h00);
      end
      chk("valid0", out_valid0, q0.size() != 0);
      chk("occ0", occ0, q0.size());
      chk("ready0", in_ready0, (q0.size() == 0) || out_ready);
      if (q0.size() != 0) begin
         chk("data0", out_data0, q0[0][31:0]);
         chk("ctrl0", out_ctrl0, q0[0][39:32]);
      end else begin
         chk("bubble_ctrl0", out_ctrl0, 8'h00);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", out_valid1, 1'b0);
      chk("rst_data", out_data1, 32'h0);
      chk("rst_ctrl", out_ctrl1, 8'h0);
      chk("rst_occ", occ1, 2'd0);
      chk("rst_ready", in_ready1, 1'b1);
      chk("rst_ready0", in_ready0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: single entry, one-cycle latency
      out_ready = 1'b1;
      drive(1'b1, 32'h10, 8'h05);
      tick();
      chk("t1_valid", out_valid1, 1'b1);
      chk("t1_data", out_data1, 32'h10);
      chk("t1_ctrl", out_ctrl1, 8'h05);
      chk("t1_occ", occ1, 2'd1);

      // 2: full-rate stream
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i, 8'h20 + 8'(i));
         tick();
         chk("t2_data", out_data1, i);
         chk("t2_occ", occ1, 2'd1);
         chk("t2_ready", in_ready1, 1'b1);
      end
      drive(1'b0, 32'hDEAD, 8'hFF);
      tick();
      chk("t2_drain_valid", out_valid1, 1'b0);
      chk("t2_bubble_ctrl", out_ctrl1, 8'h00);

      // 3: backpressure fills the skid entry
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 8'h03);
      tick();
      drive(1'b1, 32'hB, 8'h04);
      tick();
      drive(1'b0, 32'h0, 8'h00);
      chk("t3_occ", occ1, 2'd2);
      chk("t3_ready", in_ready1, 1'b0);
      chk("t3_head", out_data1, 32'hA);
      tick();
      chk("t3_hold", out_data1, 32'hA);
      out_ready = 1'b1;
      tick();
      chk("t3_second", out_data1, 32'hB);
      chk("t3_ready_back", in_ready1, 1'b1);
      chk("t3_occ_one", occ1, 2'd1);
      tick();
      chk("t3_empty", out_valid1, 1'b0);

      // 4: flush while full drops the offered entry
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 8'h03);
      tick();
      drive(1'b1, 32'hB, 8'h04);
      tick();
      chk("t4_full", occ1, 2'd2);
      flush = 1'b1;
      drive(1'b1, 32'hC, 8'hFF);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 8'h00);
      chk("t4_occ", occ1, 2'd0);
      chk("t4_valid", out_valid1, 1'b0);
      chk("t4_ctrl", out_ctrl1, 8'h00);
      chk("t4_ready", in_ready1, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_c", out_valid1, 1'b0);
      end

      // 5: asynchronous reset mid-stream
      drive(1'b1, 32'h1, 8'h11);
      tick();
      drive(1'b1, 32'h2, 8'h22);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_valid", out_valid1, 1'b0);
      chk("t5_occ", occ1, 2'd0);
      chk("t5_ready", in_ready1, 1'b1);
      chk("t5_ctrl", out_ctrl1, 8'h00);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      drive(1'b1, 32'h3, 8'h33);
      tick();
      chk("t5_after", out_data1, 32'h3);
      chk("t5_after_valid", out_valid1, 1'b1);
      drive(1'b0, 32'h0, 8'h00);
      tick();

      // 6: no-skid instance, combinational ready
      out_ready = 1'b0;
      drive(1'b1, 32'h60, 8'h06);
      tick();
      drive(1'b1, 32'h61, 8'h07);
      #1;
      chk("t6_ready_low", in_ready0, 1'b0);
      chk("t6_head", out_data0, 32'h60);
      out_ready = 1'b1;
      #1;
      chk("t6_ready_high", in_ready0, 1'b1);
      tick();
      chk("t6_replace", out_data0, 32'h61);
      chk("t6_occ", occ0, 2'd1);
      drive(1'b0, 32'h0, 8'h00);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
